char_stream_rx: RTL and testbench

Serial front end for the text-checking path: receives 8N1 asynchronous serial characters on a single line and delivers them as bytes through a small FIFO with a valid/ready handshake. It sits directly upstream of the begin/end block checker. Integration advances the checker only on cycles where a byte is accepted (`out_valid && out_ready`). No case folding or character filtering is done here; bytes are delivered exactly as received.

---
 rtl/char_stream_rx_pkg.sv | 16 +
 rtl/char_stream_rx_byte_fifo.sv | 46 ++++
 rtl/char_stream_rx.sv | 138 +++++++++++++
 tb/tb_char_stream_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/char_stream_rx_pkg.sv
// Shared definitions for the serial character receiver: FSM state encodings
// and the character constants used by the downstream text checker.
// No logic here; imported by the receiver top and its FIFO.
package char_stream_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] CH_SPACE = 8'd32;
  localparam logic [7:0] CH_NL    = 8'd10;

endpackage

// File: rtl/char_stream_rx_byte_fifo.sv
// Byte FIFO between the serial deframer and the consumer.
// Latency: a push is visible on dout/empty the cycle after it is written.
// Backpressure: pop is ignored when empty; push while full without a pop is ignored.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot the write lands in, so full+pop may push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  // Storage and pointer update; storage is cleared so dout reads 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/char_stream_rx.sv
// 8N1 serial receiver delivering bytes through a small FIFO with valid/ready.
// Latency: ~9.5 bit times + 3 cycles from start-bit edge to out_valid.
// Backpressure: bytes queue in the FIFO; a byte completing while full is dropped and flags overrun.
module char_stream_rx
  import char_stream_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q, rxs_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            byte_done;
  logic            fifo_push, fifo_pop, fifo_empty, fifo_full;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Deframer state, counters, shift register and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state: start bit checked mid-bit, then data/stop sampled every full bit time.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    frame_err_d = frame_err_q;
    byte_done   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          if (!rxs_q) begin
            state_d = RX_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = RX_IDLE;  // glitch, not a real start bit
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          sh_d  = {rxs_q, sh_q[7:1]};  // LSB arrives first
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = RX_STOP;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          if (rxs_q) byte_done   = 1'b1;
          else       frame_err_d = 1'b1;
          cnt_d   = '0;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign fifo_pop  = out_valid && out_ready;
  // A completed byte is kept unless the FIFO is full and nothing leaves this cycle.
  assign fifo_push = byte_done && (!fifo_full || fifo_pop);
  assign overrun_d = overrun_q || (byte_done && fifo_full && !fifo_pop);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (sh_q),
    .pop   (fifo_pop),
    .dout  (out),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_char_stream_rx.sv
// Scoreboard bench for char_stream_rx: serial frames are driven bit by bit,
// expected bytes are queued at send time and a negedge monitor compares each accepted byte.
module tb_char_stream_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       out_ready;
  logic [7:0] out;
  logic       out_valid, frame_err, overrun;

  logic ready_manual = 1'b0;
  logic rand_ready   = 1'b0;
  logic rand_bit     = 1'b0;
  assign out_ready = rand_ready ? rand_bit : ready_manual;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] exp_q[$];
  bit exp_ferr = 1'b0;
  bit exp_ovr  = 1'b0;

  char_stream_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Random consumer readiness, refreshed just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: every accepted byte must be the oldest expected one.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_byte", {24'd0, out}, 32'h100);
      end else begin
        e = exp_q.pop_front();
        chk("byte", {24'd0, out}, {24'd0, e});
      end
    end
  end

  // Reference model: a good frame joins the queue unless the FIFO is already
  // full and the consumer does not take a byte on the completing cycle.
  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit pop_at_push);
    if (bad_stop) exp_ferr = 1'b1;
    else if (exp_q.size() >= DEPTH && !pop_at_push) exp_ovr = 1'b1;
    else exp_q.push_back(b);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = !bad_stop;
    if (pop_at_push) begin
      // Stop bit is sampled 10 edges into the stop bit (2 sync + half bit).
      tick(10);
      ready_manual = 1'b1;
      tick(1);
      ready_manual = 1'b0;
      tick(CPB - 11);
    end else begin
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    ready_manual = 1'b1;
    while (exp_q.size() != 0 && k < limit) begin
      tick(1);
      k++;
    end
    chk("drain_done", exp_q.size(), 0);
    tick(2);
    chk("empty_after_drain", {31'd0, out_valid}, 0);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, exp_ferr});
    chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    rx = 1'b1;
    ready_manual = 1'b0;
    tick(3);
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    chk({tag, "_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_out"}, {24'd0, out}, 0);
    check_flags(tag);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] word [5];
    word[0] = 8'h62; word[1] = 8'h65; word[2] = 8'h67; word[3] = 8'h69; word[4] = 8'h6E;

    do_reset("reset");

    // Single byte, held until the consumer is ready.
    send_frame(8'h62, 1'b0, 1'b0);
    tick(2);
    chk("single_valid", {31'd0, out_valid}, 1);
    chk("single_head", {24'd0, out}, 32'h62);
    wait_drain(20);
    check_flags("single");

    // "begin" back-to-back with the consumer always ready.
    ready_manual = 1'b1;
    for (int i = 0; i < 5; i++) send_frame(word[i], 1'b0, 1'b0);
    wait_drain(50);
    check_flags("begin");

    // Short low glitch must not produce a byte or a flag.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    chk("glitch_valid", {31'd0, out_valid}, 0);
    check_flags("glitch");

    // Random bytes, random gaps, random consumer readiness.
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      tick($urandom_range(0, 30));
    end
    rand_ready = 1'b0;
    wait_drain(100);
    check_flags("random");

    // Framing error is flagged and stays set across good frames.
    send_frame(8'h41, 1'b1, 1'b0);
    tick(32);
    check_flags("ferr");
    send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    wait_drain(50);
    check_flags("ferr_sticky");

    // Five bytes into a four-deep FIFO with no consumer: fifth is dropped.
    ready_manual = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(8'h30 + 8'(i), 1'b0, 1'b0);
    tick(2);
    check_flags("overrun");
    chk("overrun_valid", {31'd0, out_valid}, 1);
    wait_drain(50);

    // Full FIFO with a pop on the completing cycle: nothing is dropped.
    do_reset("reset2");
    for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1'b0, 1'b0);
    send_frame(8'hA4, 1'b0, 1'b1);
    tick(2);
    check_flags("full_pop");
    wait_drain(50);

    // Reset mid-frame discards queued and partial bytes.
    ready_manual = 1'b0;
    send_frame(8'hC3, 1'b0, 1'b0);
    rx = 1'b0;
    tick(CPB + 40);
    do_reset("midreset");
    ready_manual = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);
    wait_drain(50);
    check_flags("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
